// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode, flag and state types for alu_seq and alu_mul_seq,
// plus the signed-overflow helpers used by the add/subtract datapath.
package alu_pkg;

  typedef enum logic [2:0] {
    ADD      = 3'd0,
    SUBTRACT = 3'd1,
    AND_OP   = 3'd2,
    OR_OP    = 3'd3,
    XOR_OP   = 3'd4,
    NOT_OP   = 3'd5,
    REG      = 3'd6,
    MUL      = 3'd7
  } instruction_code;

  typedef struct packed {
    logic v;
    logic n;
    logic z;
    logic c;
  } alu_flags_t;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } alu_state_t;

  // Subtraction adds the inverted second operand, so overflow needs differing signs.
  function automatic logic add_overflow(input logic a_msb, input logic b_msb,
                                        input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  function automatic logic sub_overflow(input logic a_msb, input logic b_msb,
                                        input logic r_msb);
    return (a_msb != b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: unsigned shift-add multiplier, one partial product per clock,
// exactly WIDTH busy cycles per product. Used by alu_seq under ALU_MUL_EN.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               last_step;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    last_step = busy_q && (cnt_q == CW'(WIDTH - 1));

    if (busy_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (last_step) begin
        busy_d = 1'b0;
      end
    end else if (start) begin
      mcand_d  = {{WIDTH{1'b0}}, a};
      acc_d    = '0;
      mplier_d = b;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  // done and product are combinational on the final step so the parent registers them at that same edge.
  assign busy    = busy_q;
  assign done    = last_step;
  assign product = acc_d;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshake, stored-carry chaining and
// flags {V,N,Z,C}. Defining ALU_MUL_EN adds the multi-cycle unsigned multiply.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op_code,
  input  logic [WIDTH-1:0] i_1,
  input  logic [WIDTH-1:0] i_2,
  input  logic             carry_ce,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o_main,
  output logic [WIDTH-1:0] o_high,
  output logic [3:0]       flags
);

  localparam int MSB = WIDTH - 1;

  instruction_code op;
  logic             accept;
  logic             idle;
  logic             cin;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] main_d;
  logic             carry_d;
  logic             ovf_d;
  alu_flags_t       flags_d;

  logic             out_valid_q;
  logic [WIDTH-1:0] o_main_q;
  logic [WIDTH-1:0] o_high_q;
  alu_flags_t       flags_q;

  assign op = instruction_code'(op_code);

`ifdef ALU_MUL_EN
  alu_state_t         state_q;
  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;
  alu_flags_t         mul_flags_d;

  assign mul_start = accept && (op == MUL);

  alu_mul_seq #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start),
    .a      (i_1),
    .b      (i_2),
    .busy   (mul_busy),
    .done   (mul_done),
    .product(mul_product)
  );

  always_comb begin
    mul_flags_d.v = 1'b0;
    mul_flags_d.n = mul_product[MSB];
    mul_flags_d.z = (mul_product[WIDTH-1:0] == '0);
    mul_flags_d.c = (mul_product[2*WIDTH-1:WIDTH] != '0);
  end

  assign idle = (state_q == IDLE) && !mul_busy;
`else
  assign idle = 1'b1;
`endif

  // A new op may enter only when the output register is free or draining this cycle.
  assign in_ready = !rst && idle && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    cin      = carry_ce & flags_q.c;
    sum_ext  = {1'b0, i_1} + {1'b0, i_2} + {{WIDTH{1'b0}}, cin};
    diff_ext = {1'b0, i_1} - {1'b0, i_2} - {{WIDTH{1'b0}}, cin};
    main_d   = '0;
    carry_d  = flags_q.c;
    ovf_d    = 1'b0;

    case (op)
      ADD: begin
        main_d  = sum_ext[WIDTH-1:0];
        carry_d = sum_ext[WIDTH];
        ovf_d   = add_overflow(i_1[MSB], i_2[MSB], sum_ext[MSB]);
      end
      SUBTRACT: begin
        main_d  = diff_ext[WIDTH-1:0];
        carry_d = diff_ext[WIDTH];
        ovf_d   = sub_overflow(i_1[MSB], i_2[MSB], diff_ext[MSB]);
      end
      AND_OP:  main_d = i_1 & i_2;
      OR_OP:   main_d = i_1 | i_2;
      XOR_OP:  main_d = i_1 ^ i_2;
      NOT_OP:  main_d = ~i_1;
      REG:     main_d = i_2;
      MUL: begin
`ifndef ALU_MUL_EN
        main_d = WIDTH'(1);
`endif
      end
      default: main_d = '0;
    endcase

    flags_d.v = ovf_d;
    flags_d.n = main_d[MSB];
    flags_d.z = (main_d == '0);
    flags_d.c = carry_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef ALU_MUL_EN
      state_q     <= IDLE;
`endif
      out_valid_q <= 1'b0;
      o_main_q    <= '0;
      o_high_q    <= '0;
      flags_q     <= '0;
    end else begin
`ifdef ALU_MUL_EN
      case (state_q)
        IDLE: begin
          if (mul_start) begin
            state_q     <= MUL_BUSY;
            out_valid_q <= 1'b0;
          end else if (accept) begin
            out_valid_q <= 1'b1;
            o_main_q    <= main_d;
            o_high_q    <= '0;
            flags_q     <= flags_d;
          end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        MUL_BUSY: begin
          if (mul_done) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b1;
            o_main_q    <= mul_product[WIDTH-1:0];
            o_high_q    <= mul_product[2*WIDTH-1:WIDTH];
            flags_q     <= mul_flags_d;
          end
        end
        default: state_q <= IDLE;
      endcase
`else
      if (accept) begin
        out_valid_q <= 1'b1;
        o_main_q    <= main_d;
        o_high_q    <= '0;
        flags_q     <= flags_d;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign o_main    = o_main_q;
  assign o_high    = o_high_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and random checks of alu_seq (WIDTH=8) against an
// arithmetic reference model; MUL expectations follow ALU_MUL_EN.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op_code;
  logic [W-1:0] i_1;
  logic [W-1:0] i_2;
  logic         carry_ce;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] o_main;
  logic [W-1:0] o_high;
  logic [3:0]   flags;

  int n_checks = 0;
  int n_fail   = 0;
  int model_c  = 0;

  typedef struct packed {
    logic [W-1:0] main;
    logic [W-1:0] high;
    logic [3:0]   fl;
  } exp_t;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op_code  (op_code),
    .i_1      (i_1),
    .i_2      (i_2),
    .carry_ce (carry_ce),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .o_main   (o_main),
    .o_high   (o_high),
    .flags    (flags)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int to_signed(input int x);
    return (x >= 2 ** (W - 1)) ? x - 2 ** W : x;
  endfunction

  // Reference: plain integer arithmetic on the current stored C.
  function automatic exp_t model(input int op, input int a, input int b, input int ce);
    exp_t        e;
    int          cin, r, sr, c, v, prod;
    logic [31:0] rr;
    cin  = (ce != 0) ? model_c : 0;
    c    = model_c;
    v    = 0;
    r    = 0;
    e    = '0;
    case (op)
      0: begin
        r  = a + b + cin;
        c  = (r >= 2 ** W) ? 1 : 0;
        sr = to_signed(a) + to_signed(b) + cin;
        v  = (sr > 2 ** (W - 1) - 1 || sr < -(2 ** (W - 1))) ? 1 : 0;
      end
      1: begin
        r  = a - b - cin;
        c  = (a < b + cin) ? 1 : 0;
        sr = to_signed(a) - to_signed(b) - cin;
        v  = (sr > 2 ** (W - 1) - 1 || sr < -(2 ** (W - 1))) ? 1 : 0;
      end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = ~a;
      6: r = b;
      default: begin
`ifdef ALU_MUL_EN
        prod   = a * b;
        r      = prod;
        e.high = W'(prod / (2 ** W));
        c      = (prod / (2 ** W) != 0) ? 1 : 0;
`else
        prod   = 0;
        r      = 1 + prod;
`endif
      end
    endcase
    rr     = r;
    e.main = rr[W-1:0];
    e.fl   = {v[0], e.main[W-1], (e.main == '0), c[0]};
    return e;
  endfunction

  function automatic int latency_of(input int op);
`ifdef ALU_MUL_EN
    return (op == 7) ? W + 1 : 1;
`else
    return (op == 7) ? 1 : 1;
`endif
  endfunction

  // Present one op, wait (bounded) for acceptance and result, compare everything.
  task automatic send(input int op, input int a, input int b, input int ce,
                      input string tag, output exp_t e);
    int   waited;
    logic ready_seen;
    op_code   = 3'(op);
    i_1       = W'(a);
    i_2       = W'(b);
    carry_ce  = ce[0];
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check({tag, ".in_ready"}, in_ready, 1);
    e = model(op, a, b, ce);
    @(posedge clk); #1;
    in_valid   = 1'b0;
    model_c    = int'(e.fl[0]);
    waited     = 1;
    ready_seen = 1'b0;
    while (!out_valid && waited < W + 4) begin
      ready_seen |= in_ready;
      @(posedge clk); #1;
      waited++;
    end
    check({tag, ".latency"}, waited, latency_of(op));
    if (latency_of(op) > 1) check({tag, ".busy_ready"}, ready_seen, 0);
    check({tag, ".out_valid"}, out_valid, 1);
    check({tag, ".o_main"}, o_main, e.main);
    check({tag, ".o_high"}, o_high, e.high);
    check({tag, ".flags"}, flags, e.fl);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t        e, held;
    logic        seen;
    int          op, a, b, ce, r;
    int          ops4 [4];
    int          as4  [4];

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op_code = '0; i_1 = '0; i_2 = '0; carry_ce = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.in_ready", in_ready, 0);
    check("rst.out_valid", out_valid, 0);
    check("rst.o_main", o_main, 0);
    check("rst.o_high", o_high, 0);
    check("rst.flags", flags, 0);
    rst = 1'b0;
    #1;
    check("post_rst.in_ready", in_ready, 1);

    send(int'(ADD), 'hF0, 'h20, 0, "add_f0_20", e);
    check("plan.add1.main", o_main, 'h10);
    check("plan.add1.flags", flags, 4'b0001);
    send(int'(ADD), 'h01, 'h01, 1, "add_chain", e);
    check("plan.add2.main", o_main, 'h03);
    check("plan.add2.flags", flags, 4'b0000);
    send(int'(ADD), 'h7F, 'h01, 0, "add_ovf", e);
    check("plan.add3.main", o_main, 'h80);
    check("plan.add3.flags", flags, 4'b1100);
    send(int'(SUBTRACT), 'h10, 'h20, 0, "sub_borrow", e);
    check("plan.sub.main", o_main, 'hF0);
    check("plan.sub.flags", flags, 4'b0101);
    send(int'(XOR_OP), 'hAA, 'hAA, 0, "xor_zero", e);
    check("plan.xor.main", o_main, 'h00);
    check("plan.xor.flags", flags, 4'b0011);
    send(int'(SUBTRACT), 'h05, 'h05, 1, "sub_bin", e);

    send(int'(MUL), 'hFF, 'hFF, 0, "mul_ff_ff", e);
    check("plan.mul.main", o_main, 'h01);
`ifdef ALU_MUL_EN
    check("plan.mul.high", o_high, 'hFE);
`else
    check("plan.mul.high", o_high, 'h00);
`endif

    // Output stall: result held, next op waits, nothing lost.
    send(int'(ADD), 'h11, 'h22, 0, "stall_a", held);
    out_ready = 1'b0;
    op_code = 3'(int'(SUBTRACT)); i_1 = 'h50; i_2 = 'h05; carry_ce = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall.in_ready", in_ready, 0);
      check("stall.out_valid", out_valid, 1);
      check("stall.o_main", o_main, held.main);
      check("stall.flags", flags, held.fl);
      @(posedge clk); #1;
    end
    send(int'(SUBTRACT), 'h50, 'h05, 0, "stall_b", e);
    check("stall_b.main", o_main, 'h4B);

    ops4 = '{int'(AND_OP), int'(OR_OP), int'(NOT_OP), int'(REG)};
    as4  = '{'hF0, 'h0F, 'h0F, 'h99};
    for (int k = 0; k < 4; k++) send(ops4[k], as4[k], 'h3C, 0, "b2b", e);

    // Reset in the middle of work: no result may appear afterwards.
`ifdef ALU_MUL_EN
    op_code = 3'(int'(MUL)); i_1 = 'h12; i_2 = 'h34; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("rst_mul.accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
`else
    send(int'(XOR_OP), 'h0F, 'hF1, 0, "rst_pending", e);
    out_ready = 1'b0;
    @(posedge clk); #1;
`endif
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid.out_valid", out_valid, 0);
    check("rst_mid.o_main", o_main, 0);
    check("rst_mid.o_high", o_high, 0);
    check("rst_mid.flags", flags, 0);
    check("rst_mid.in_ready", in_ready, 0);
    rst = 1'b0;
    model_c = 0;
    out_ready = 1'b1;
    #1;
    check("rst_mid.ready_after", in_ready, 1);
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      seen |= out_valid;
    end
    check("rst_mid.no_output", seen, 0);
    send(int'(ADD), 'h02, 'h03, 0, "add_after_rst", e);
    check("plan.rst_add.main", o_main, 'h05);

    for (int n = 0; n < 150; n++) begin
      op = $urandom_range(0, 7);
      a  = $urandom_range(0, 255);
      b  = $urandom_range(0, 255);
      ce = $urandom_range(0, 1);
      send(op, a, b, ce, "rand", e);
      if ($urandom_range(0, 3) == 0) begin
        out_ready = 1'b0;
        r = $urandom_range(1, 3);
        repeat (r) begin
          @(posedge clk); #1;
          check("rand.hold_valid", out_valid, 1);
          check("rand.hold_main", o_main, e.main);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
